// File: rtl/clock_pkg.sv
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared limits, field encoding and 12-hour helper for the
//                time-of-day scan controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HOUR_MAX   = 23;
    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_e;

    // Returns {pm, display hour}; midnight shows as 12 AM, noon as 12 PM.
    function automatic logic [6:0] hour12(input logic [4:0] hour);
        logic       pm;
        logic [5:0] disp;
        pm = (hour >= 5'd12);
        if (hour == 5'd0)
            disp = 6'd12;
        else if (hour > 5'd12)
            disp = {1'b0, hour - 5'd12};
        else
            disp = {1'b0, hour};
        return {pm, disp};
    endfunction

endpackage

`default_nettype wire

// File: rtl/time_counter.sv
// ============================================================================
//  Module      : time_counter
//  Description : Hours/minutes/seconds registers with 1 Hz tick and set-mode
//                increment handling.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module time_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec
);

    localparam logic [5:0] C_SEC_LAST  = 6'(SEC_MAX);
    localparam logic [5:0] C_MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0] C_HOUR_LAST = 5'(HOUR_MAX);

    logic [4:0] r_hour;
    logic [5:0] r_min;
    logic [5:0] r_sec;

    // Any set-mode pulse swallows a coincident tick so the user edit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour <= 5'd0;
            r_min  <= 6'd0;
            r_sec  <= 6'd0;
        end else if (inc_min || inc_hour) begin
            if (inc_min) begin
                r_min <= (r_min == C_MIN_LAST) ? 6'd0 : r_min + 6'd1;
                r_sec <= 6'd0;
            end
            if (inc_hour)
                r_hour <= (r_hour == C_HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
        end else if (tick) begin
            if (r_sec == C_SEC_LAST) begin
                r_sec <= 6'd0;
                if (r_min == C_MIN_LAST) begin
                    r_min  <= 6'd0;
                    r_hour <= (r_hour == C_HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
                end else begin
                    r_min <= r_min + 6'd1;
                end
            end else begin
                r_sec <= r_sec + 6'd1;
            end
        end
    end

    assign hour = r_hour;
    assign min  = r_min;
    assign sec  = r_sec;

endmodule

`default_nettype wire

// File: rtl/time_scan_ctrl.sv
// ============================================================================
//  Module      : time_scan_ctrl
//  Description : Time-of-day counters plus 6-digit multiplexed scan sharing a
//                single external tens/units splitter. Optional macro H12_EN
//                presents the hour field in 12-hour form with a PM flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module time_scan_ctrl
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [5:0] split_total,
    input  logic [3:0] split_left,
    input  logic [3:0] split_right,
    output logic [3:0] digit_val,
    output logic [5:0] digit_sel,
    output logic       pm
);

    localparam int         PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0] C_IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [4:0]    w_hour;
    logic [5:0]    w_min;
    logic [5:0]    w_sec;
    logic [5:0]    w_hour_disp;
    logic          w_pm;
    field_e        w_field;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [3:0]    r_digit_val;
    logic [5:0]    r_digit_sel;
    logic          r_pm;

    time_counter u_time_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .inc_min  (inc_min),
        .inc_hour (inc_hour),
        .hour     (w_hour),
        .min      (w_min),
        .sec      (w_sec)
    );

`ifdef H12_EN
    logic [6:0] w_h12;
    assign w_h12       = hour12(w_hour);
    assign w_hour_disp = w_h12[5:0];
    assign w_pm        = w_h12[6];
`else
    assign w_hour_disp = {1'b0, w_hour};
    assign w_pm        = 1'b0;
`endif

    // Two digit slots per field, so the field is simply the slot index halved.
    assign w_field = field_e'(r_idx[2:1]);

    always_comb begin
        split_total = 6'd0;
        case (w_field)
            FLD_HOUR: split_total = w_hour_disp;
            FLD_MIN:  split_total = w_min;
            FLD_SEC:  split_total = w_sec;
            default:  split_total = 6'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (r_presc == C_PRESC_LAST) begin
            r_presc <= '0;
            r_idx   <= (r_idx == C_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_val <= 4'd0;
            r_digit_sel <= 6'd0;
            r_pm        <= 1'b0;
        end else begin
            r_digit_val <= r_idx[0] ? split_right : split_left;
            r_digit_sel <= 6'b000001 << r_idx;
            r_pm        <= w_pm;
        end
    end

    assign digit_val = r_digit_val;
    assign digit_sel = r_digit_sel;
    assign pm        = r_pm;

endmodule

`default_nettype wire

// File: tb/tb_time_scan_ctrl.sv
// ============================================================================
//  Module      : tb_time_scan_ctrl
//  Description : Self-checking bench for time_scan_ctrl with a time-of-day
//                reference model and directed set/tick sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_scan_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic [5:0] split_total;
    logic [3:0] split_left;
    logic [3:0] split_right;
    logic [3:0] digit_val;
    logic [5:0] digit_sel;
    logic       pm;

    int n_vec = 0;
    int n_err = 0;

    time_scan_ctrl #(.SCAN_DIV(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .inc_min     (inc_min),
        .inc_hour    (inc_hour),
        .split_total (split_total),
        .split_left  (split_left),
        .split_right (split_right),
        .digit_val   (digit_val),
        .digit_sel   (digit_sel),
        .pm          (pm)
    );

    // External splitter
    assign split_left  = 4'(split_total / 6'd10);
    assign split_right = 4'(split_total % 6'd10);

    always #5 clk = ~clk;

`ifdef H12_EN
    localparam bit H12 = 1'b1;
`else
    localparam bit H12 = 1'b0;
`endif

    // ---------------- reference model ----------------
    int m_h = 0, m_m = 0, m_s = 0;
    int m_k = 0;
    int e_val = 0, e_sel = 0, e_pm = 0;

    function automatic int hour_disp(input int h);
        if (!H12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    function automatic int field_value(input int slot, input int h, input int m, input int s);
        case (slot / 2)
            0: return hour_disp(h);
            1: return m;
            default: return s;
        endcase
    endfunction

    function automatic int digit_of(input int slot, input int v);
        return (slot % 2 == 1) ? v % 10 : v / 10;
    endfunction

    // Next time in seconds of day as h*3600+m*60+s
    function automatic int next_time(input int h, input int m, input int s,
                                     input bit t, input bit im, input bit ih);
        int nh, nm, ns, tot;
        nh = h; nm = m; ns = s;
        if (im || ih) begin
            if (im) begin nm = (m + 1) % 60; ns = 0; end
            if (ih) nh = (h + 1) % 24;
        end else if (t) begin
            tot = (h * 3600 + m * 60 + s + 1) % 86400;
            nh = tot / 3600; nm = (tot / 60) % 60; ns = tot % 60;
        end
        return nh * 3600 + nm * 60 + ns;
    endfunction

    int w_slot, w_nt;
    always_comb begin
        w_slot = (m_k / D) % 6;
        w_nt   = next_time(m_h, m_m, m_s, tick, inc_min, inc_hour);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h <= 0; m_m <= 0; m_s <= 0; m_k <= 0;
            e_val <= 0; e_sel <= 0; e_pm <= 0;
        end else begin
            e_val <= digit_of(w_slot, field_value(w_slot, m_h, m_m, m_s));
            e_sel <= 1 << w_slot;
            e_pm  <= (H12 && m_h >= 12) ? 1 : 0;
            m_h   <= w_nt / 3600;
            m_m   <= (w_nt / 60) % 60;
            m_s   <= w_nt % 60;
            m_k   <= m_k + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        chk("digit_val", int'(digit_val), e_val);
        chk("digit_sel", int'(digit_sel), e_sel);
        chk("pm", int'(pm), e_pm);
        chk("split_total", int'(split_total),
            field_value((m_k / D) % 6, m_h, m_m, m_s));
    end

    // ---------------- directed stimulus ----------------
    task automatic pulses(input bit t, input bit im, input bit ih, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick = t; inc_min = im; inc_hour = ih;
            @(negedge clk); tick = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
        end
    endtask

    task automatic wait_sel(input logic [5:0] sel);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (digit_sel == sel) begin found = 1'b1; break; end
        end
        if (!found) chk("wait_sel_timeout", int'(digit_sel), int'(sel));
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        chk({name, "_model"}, m_h * 10000 + m_m * 100 + m_s, h * 10000 + m * 100 + s);
        wait_sel(6'b000001); chk({name, "_h10"}, int'(digit_val), hour_disp(h) / 10);
        wait_sel(6'b000010); chk({name, "_h1"},  int'(digit_val), hour_disp(h) % 10);
        wait_sel(6'b000100); chk({name, "_m10"}, int'(digit_val), m / 10);
        wait_sel(6'b001000); chk({name, "_m1"},  int'(digit_val), m % 10);
        wait_sel(6'b010000); chk({name, "_s10"}, int'(digit_val), s / 10);
        wait_sel(6'b100000); chk({name, "_s1"},  int'(digit_val), s % 10);
    endtask

    task automatic check_hour(input string name, input int tens, input int units, input int exp_pm);
        wait_sel(6'b000001); chk({name, "_tens"}, int'(digit_val), tens);
        wait_sel(6'b000010); chk({name, "_units"}, int'(digit_val), units);
        chk({name, "_pm"}, int'(pm), exp_pm);
    endtask

    int scan_exp[6];

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-slot at idx 3
        wait_sel(6'b001000);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sel", int'(digit_sel), 0);
        chk("rst_val", int'(digit_val), 0);
        chk("rst_pm", int'(pm), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_sel", int'(digit_sel), 1);

        // Set 13:45:07 and check scan order
        pulses(1'b0, 1'b0, 1'b1, 13);
        pulses(1'b0, 1'b1, 1'b0, 45);
        pulses(1'b1, 1'b0, 1'b0, 7);
        if (H12) scan_exp = '{0, 1, 4, 5, 0, 7};
        else     scan_exp = '{1, 3, 4, 5, 0, 7};
        for (int i = 0; i < 6; i++) begin
            wait_sel(6'(1 << i));
            chk($sformatf("scan_digit%0d", i), int'(digit_val), scan_exp[i]);
        end
        chk("scan_pm", int'(pm), H12 ? 1 : 0);

        // Rollover from 23:59:59
        pulses(1'b0, 1'b0, 1'b1, 10);
        pulses(1'b0, 1'b1, 1'b0, 14);
        pulses(1'b1, 1'b0, 1'b0, 59);
        check_time("t235959", 23, 59, 59);
        pulses(1'b1, 1'b0, 1'b0, 1);
        check_time("roll_day", 0, 0, 0);
        check_hour("h0", H12 ? 1 : 0, H12 ? 2 : 0, 0);

        // 00:59:59 -> 01:00:00
        pulses(1'b0, 1'b1, 1'b0, 59);
        pulses(1'b1, 1'b0, 1'b0, 59);
        pulses(1'b1, 1'b0, 1'b0, 1);
        check_time("roll_hour", 1, 0, 0);

        // 10:59:30 with tick + inc_min together
        pulses(1'b0, 1'b0, 1'b1, 9);
        pulses(1'b0, 1'b1, 1'b0, 59);
        pulses(1'b1, 1'b0, 1'b0, 30);
        check_time("t105930", 10, 59, 30);
        pulses(1'b1, 1'b1, 1'b0, 1);
        check_time("tick_incmin", 10, 0, 0);

        // 23:10:05 with tick + inc_hour together
        pulses(1'b0, 1'b0, 1'b1, 13);
        pulses(1'b0, 1'b1, 1'b0, 10);
        pulses(1'b1, 1'b0, 1'b0, 5);
        pulses(1'b1, 1'b0, 1'b1, 1);
        check_time("tick_inchour", 0, 10, 5);

        // Hour presentation at 12 and 13
        pulses(1'b0, 1'b0, 1'b1, 12);
        check_hour("h12", 1, 2, H12 ? 1 : 0);
        pulses(1'b0, 1'b0, 1'b1, 1);
        check_hour("h13", H12 ? 0 : 1, H12 ? 1 : 3, H12 ? 1 : 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
